// File: rtl/line_win_if.sv
// Column-in / window-out stream bundle for the horizontal window generator.
interface line_win_if #(
    parameter int DBUF_DW = 8,
    parameter int KRNV_SZ = 6,
    parameter int KRNH_SZ = 5
);
    logic [DBUF_DW*KRNV_SZ-1:0]         i_data;
    logic                               i_href;
    logic                               i_hstr;
    logic                               i_hend;
    logic                               i_vstr;
    logic                               i_vend;
    logic [DBUF_DW*KRNV_SZ*KRNH_SZ-1:0] o_data;
    logic                               o_dvld;
    logic                               o_hstr;
    logic                               o_hend;
    logic                               o_vstr;
    logic                               o_vend;
    logic                               o_busy;
    logic                               o_err;

    modport master (
        output i_data, i_href, i_hstr, i_hend, i_vstr, i_vend,
        input  o_data, o_dvld, o_hstr, o_hend, o_vstr, o_vend, o_busy, o_err
    );

    modport slave (
        input  i_data, i_href, i_hstr, i_hend, i_vstr, i_vend,
        output o_data, o_dvld, o_hstr, o_hend, o_vstr, o_vend, o_busy, o_err
    );
endinterface

// File: rtl/line_win.sv
// Horizontal sliding-window generator: turns a stream of pixel columns into
// KRNV_SZ x KRNH_SZ windows centred on every column, with zero or replicate
// edge padding. win[KRNH_SZ-1] always holds the newest column.
module line_win #(
    parameter int DBUF_DW = 8,
    parameter int KRNV_SZ = 6,
    parameter int KRNH_SZ = 5
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     r_pad_mode,
    line_win_if.slave bus
);
    localparam int HALF = (KRNH_SZ - 1) / 2;
    localparam int CW   = DBUF_DW * KRNV_SZ;
    localparam int AW   = $clog2(KRNH_SZ + 1);
    localparam int IW   = $clog2(KRNH_SZ);
    localparam logic [AW-1:0] ACC_ONE  = AW'(1);
    localparam logic [AW-1:0] ACC_FULL = AW'(HALF + 1);

    typedef logic [CW-1:0] col_t;
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t          state;
    col_t            win [KRNH_SZ];
    logic [AW-1:0]   acc;
    logic [AW-1:0]   flush_cnt;
    logic            pad_mode;
    logic            first_pend;
    logic            vstr_pend;
    logic            vend_pend;

    logic            start;
    logic            mode;
    logic [AW-1:0]   acc_n;
    int              n;
    col_t            shf [KRNH_SZ];
    col_t            fsh [KRNH_SZ];
    col_t            pre [KRNH_SZ];
    col_t            ewin [KRNH_SZ];
    col_t            pad_l;
    col_t            pad_r;
    logic            emit;
    logic            elast;
    logic            err;
    logic            vend_take;
    logic [CW*KRNH_SZ-1:0] ewin_flat;

    assign bus.o_busy = (state != IDLE);

    // Next window candidates: column shift, right-pad flush shift, and the
    // realigned store used when a line ends before the window has filled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        start = bus.i_href && bus.i_hstr && (state == IDLE || state == FLUSH);
        mode  = start ? r_pad_mode : pad_mode;
        acc_n = start ? ACC_ONE : ((acc == ACC_FULL) ? acc : acc + 1'b1);
        n     = int'(acc_n);
        for (int k = 0; k < KRNH_SZ - 1; k++) begin
            shf[k] = start ? (r_pad_mode ? bus.i_data : '0) : win[k+1];
            fsh[k] = win[k+1];
        end
        shf[KRNH_SZ-1] = bus.i_data;
        fsh[KRNH_SZ-1] = pad_mode ? win[KRNH_SZ-1] : '0;
        // Short line: place column 0 one slot right of centre so that the
        // first flush shift lands it exactly on the centre slot.
        pad_l  = mode ? shf[IW'(KRNH_SZ - n)] : '0;
        pad_r  = mode ? shf[KRNH_SZ-1] : '0;
        pre[0] = pad_l;
        for (int k = 1; k < KRNH_SZ; k++) begin
            if (k <= HALF)
                pre[k] = pad_l;
            else if (k - 1 - HALF < n)
                pre[k] = shf[IW'(KRNH_SZ - n + k - 1 - HALF)];
            else
                pre[k] = pad_r;
        end

        emit  = 1'b0;
        elast = 1'b0;
        err   = 1'b0;
        ewin  = fsh;
        unique case (state)
            IDLE:  err = bus.i_href && !bus.i_hstr;
            FILL:  begin
                if (bus.i_href && acc_n == ACC_FULL) begin
                    emit = 1'b1;
                    ewin = shf;
                end
            end
            RUN:   begin
                emit = bus.i_href;
                ewin = shf;
            end
            FLUSH: begin
                err = bus.i_href;
                if (!start) begin
                    emit  = 1'b1;
                    elast = (flush_cnt == ACC_ONE);
                end
            end
            default: ;
        endcase

        vend_take = vend_pend && ((emit && elast) || (state == IDLE && !start));
        ewin_flat = '0;
        for (int k = 0; k < KRNH_SZ; k++)
            ewin_flat[k*CW +: CW] = ewin[k];
    end

    // Line FSM, window store, frame flags and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            // NOTE: the window store is cleared on reset so an aborted line leaves no residue.
            for (int k = 0; k < KRNH_SZ; k++)
                win[k] <= '0;
            acc        <= '0;
            flush_cnt  <= '0;
            pad_mode   <= 1'b0;
            first_pend <= 1'b0;
            vstr_pend  <= 1'b0;
            vend_pend  <= 1'b0;
            bus.o_data <= '0;
            bus.o_dvld <= 1'b0;
            bus.o_hstr <= 1'b0;
            bus.o_hend <= 1'b0;
            bus.o_vstr <= 1'b0;
            bus.o_vend <= 1'b0;
            bus.o_err  <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
            bus.o_err  <= err;
            bus.o_dvld <= emit;
            bus.o_data <= emit ? ewin_flat : '0;
            bus.o_hstr <= emit && first_pend;
            bus.o_hend <= emit && elast;
            bus.o_vstr <= emit && first_pend && vstr_pend;
            bus.o_vend <= vend_take;
            vstr_pend  <= bus.i_vstr || (vstr_pend && !(emit && first_pend));
            vend_pend  <= bus.i_vend || (vend_pend && !vend_take);
            if (emit)
                first_pend <= 1'b0;

            if (start) begin
                acc        <= ACC_ONE;
                pad_mode   <= r_pad_mode;
                first_pend <= 1'b1;
                if (bus.i_hend) begin
                    win       <= pre;
                    flush_cnt <= ACC_ONE;
                    state     <= FLUSH;
                end else begin
                    win   <= shf;
                    state <= FILL;
                end
            end else begin
                unique case (state)
                    FILL: if (bus.i_href) begin
                        acc <= acc_n;
                        win <= shf;
                        if (acc_n == ACC_FULL) begin
                            flush_cnt <= AW'(HALF);
                            state     <= bus.i_hend ? FLUSH : RUN;
                        end else if (bus.i_hend) begin
                            win       <= pre;
                            flush_cnt <= acc_n;
                            state     <= FLUSH;
                        end
                    end
                    RUN: if (bus.i_href) begin
                        win <= shf;
                        if (bus.i_hend) begin
                            flush_cnt <= AW'(HALF);
                            state     <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        win       <= fsh;
                        flush_cnt <= flush_cnt - 1'b1;
                        if (flush_cnt == ACC_ONE)
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_line_win.sv
// Scoreboard bench: two instances (3- and 5-wide windows, one pixel per
// column) share one input stream; expected windows are queued per instance.
module tb_line_win;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pad_mode = 1'b0;
    logic [7:0] data = '0;
    logic href = 1'b0, hstr = 1'b0, hend = 1'b0, vstr = 1'b0, vend = 1'b0;

    always #5 clk = ~clk;

    line_win_if #(.DBUF_DW(8), .KRNV_SZ(1), .KRNH_SZ(3)) b3 ();
    line_win_if #(.DBUF_DW(8), .KRNV_SZ(1), .KRNH_SZ(5)) b5 ();

    assign b3.i_data = data;  assign b5.i_data = data;
    assign b3.i_href = href;  assign b5.i_href = href;
    assign b3.i_hstr = hstr;  assign b5.i_hstr = hstr;
    assign b3.i_hend = hend;  assign b5.i_hend = hend;
    assign b3.i_vstr = vstr;  assign b5.i_vstr = vstr;
    assign b3.i_vend = vend;  assign b5.i_vend = vend;

    line_win #(.DBUF_DW(8), .KRNV_SZ(1), .KRNH_SZ(3)) dut3 (
        .clk(clk), .rst(rst), .r_pad_mode(pad_mode), .bus(b3));
    line_win #(.DBUF_DW(8), .KRNV_SZ(1), .KRNH_SZ(5)) dut5 (
        .clk(clk), .rst(rst), .r_pad_mode(pad_mode), .bus(b5));

    typedef struct packed {
        logic [39:0] data;
        logic        hstr;
        logic        hend;
        logic        vstr;
        logic        vend;
        logic [31:0] at;
    } exp_t;

    exp_t sb [2][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    int   errs [2] = '{0, 0};
    int   exp_errs = 0;
    logic sb_en = 1'b1;
    logic vstr_m [2] = '{1'b0, 1'b0};
    logic vend_m [2] = '{1'b0, 1'b0};
    int   vals [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    function automatic logic [39:0] model_win(input int kh, input int w, input logic mode, input int x);
        logic [39:0] r;
        int half, i, v;
        r = '0;
        half = (kh - 1) / 2;
        for (int k = 0; k < kh; k++) begin
            i = x - half + k;
            if (i < 0)       v = mode ? vals[0] : 0;
            else if (i >= w) v = mode ? vals[w-1] : 0;
            else             v = vals[i];
            r[k*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Queue the windows each instance should emit, with the clock edge that
    // produces each one; an aborted line loses its flush-phase windows.
    task automatic push_line(input int w, input logic mode, input int gap, input logic abort, input logic vend_in);
        exp_t e;
        int kh, half, e_end, nw;
        for (int u = 0; u < 2; u++) begin
            kh    = u ? 5 : 3;
            half  = (kh - 1) / 2;
            e_end = edge_n + 1 + (w - 1) * (gap + 1);
            if (vend_in) vend_m[u] = 1'b1;
            for (int x = 0; x < w; x++) begin
                nw = x + half;
                if (abort && nw > w - 1) continue;
                if (nw <= w - 1)     e.at = 32'(edge_n + 1 + nw * (gap + 1));
                else if (w > half)   e.at = 32'(e_end + x - (w - 1 - half));
                else                 e.at = 32'(e_end + 1 + x);
                e.data = model_win(kh, w, mode, x);
                e.hstr = (x == 0);
                e.hend = (x == w - 1);
                e.vstr = (x == 0) && vstr_m[u];
                e.vend = e.hend && vend_m[u];
                if (x == 0) vstr_m[u] = 1'b0;
                if (e.hend) vend_m[u] = 1'b0;
                sb[u].push_back(e);
            end
        end
    endtask

    // Pad mode is flipped after the first column: it must be held per line.
    task automatic drive_line(input int w, input logic mode, input int gap, input logic vend_in);
        for (int i = 0; i < w; i++) begin
            data = 8'(vals[i]); href = 1'b1;
            hstr = (i == 0); hend = (i == w - 1);
            vend = vend_in && (i == 0);
            pad_mode = (i == 0) ? mode : ~mode;
            tick();
            href = 1'b0; hstr = 1'b0; hend = 1'b0; vend = 1'b0;
            data = 8'($urandom);
            if (i < w - 1) repeat (gap) tick();
        end
    endtask

    task automatic line(input int w, input logic mode, input int gap, input logic abort, input logic vend_in);
        push_line(w, mode, gap, abort, vend_in);
        drive_line(w, mode, gap, vend_in);
    endtask

    task automatic set_vals(input int base, input int step, input int w);
        for (int i = 0; i < w; i++) vals[i] = base + i * step;
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_k3_out"}, 64'({b3.o_dvld, b3.o_hstr, b3.o_hend, b3.o_vstr, b3.o_vend, b3.o_busy, b3.o_err}), 64'(0));
        check({tag, "_k3_data"}, 64'(b3.o_data), 64'(0));
        check({tag, "_k5_out"}, 64'({b5.o_dvld, b5.o_hstr, b5.o_hend, b5.o_vstr, b5.o_vend, b5.o_busy, b5.o_err}), 64'(0));
        check({tag, "_k5_data"}, 64'(b5.o_data), 64'(0));
    endtask

    task automatic mon(input int u, input logic dvld, input logic [39:0] d,
                       input logic hs, input logic he, input logic vs, input logic ve, input logic er);
        exp_t  e;
        string p;
        p = u ? "k5" : "k3";
        if (er) errs[u]++;
        if (!dvld) begin
            check({p, "_idle_data"}, 64'(d), 64'(0));
        end else if (sb_en) begin
            if (sb[u].size() == 0) begin
                check({p, "_unexpected_win"}, 64'(1), 64'(0));
            end else begin
                e = sb[u].pop_front();
                check({p, "_win_data"}, 64'(d), 64'(e.data));
                check({p, "_win_flags"}, 64'({hs, he, vs, ve}), 64'({e.hstr, e.hend, e.vstr, e.vend}));
                check({p, "_win_cycle"}, 64'(edge_n), 64'(e.at));
            end
        end
    endtask

    // Sample both instances half a cycle after the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, b3.o_dvld, 40'(b3.o_data), b3.o_hstr, b3.o_hend, b3.o_vstr, b3.o_vend, b3.o_err);
            mon(1, b5.o_dvld, 40'(b5.o_data), b5.o_hstr, b5.o_hend, b5.o_vstr, b5.o_vend, b5.o_err);
        end
    end

    initial begin
        int e0, e1;
        repeat (3) tick();
        chk_quiet("reset");
        rst = 1'b0;
        tick();

        // Frame start, then the basic line in zero and replicate mode.
        vstr = 1'b1; tick(); vstr = 1'b0;
        vstr_m[0] = 1'b1; vstr_m[1] = 1'b1;
        set_vals(10, 10, 4);
        line(4, 1'b0, 0, 1'b0, 1'b1); repeat (4) tick();
        line(4, 1'b1, 0, 1'b0, 1'b0); repeat (4) tick();

        // Two-column line: 5-wide windows come out of FLUSH, then IDLE.
        vals[0] = 7; vals[1] = 9;
        line(2, 1'b1, 0, 1'b0, 1'b0);
        tick();
        check("w2_k5_busy_flush", 64'(b5.o_busy), 64'(1));
        check("w2_k3_busy_done", 64'(b3.o_busy), 64'(0));
        tick();
        check("w2_k5_busy_idle", 64'(b5.o_busy), 64'(0));
        repeat (2) tick();

        // Single-column lines.
        vals[0] = 55;
        line(1, 1'b1, 0, 1'b0, 1'b0); repeat (3) tick();
        line(1, 1'b0, 0, 1'b0, 1'b0); repeat (3) tick();

        // Alternate-cycle gaps.
        e0 = errs[0]; e1 = errs[1];
        set_vals(1, 1, 6);
        line(6, 1'b0, 1, 1'b0, 1'b0); repeat (4) tick();
        check("gap_k3_no_err", 64'(errs[0]), 64'(e0));
        check("gap_k5_no_err", 64'(errs[1]), 64'(e1));

        // Next line starts the cycle after i_hend: flush aborted.
        set_vals(100, 1, 6);
        line(6, 1'b1, 0, 1'b1, 1'b0);
        set_vals(200, 3, 5);
        exp_errs++;
        line(5, 1'b0, 0, 1'b0, 1'b0); repeat (4) tick();

        // Stray column during FLUSH is dropped, flush carries on.
        set_vals(3, 3, 4);
        line(4, 1'b0, 0, 1'b0, 1'b0);
        href = 1'b1; data = 8'd99; tick(); href = 1'b0;
        exp_errs++;
        repeat (4) tick();

        // Stray column in IDLE.
        href = 1'b1; tick(); href = 1'b0;
        exp_errs++;
        repeat (2) tick();

        // Frame end with no active line: pulse two cycles later.
        vend = 1'b1; tick(); vend = 1'b0;
        tick();
        check("idle_vend_k3", 64'(b3.o_vend), 64'(1));
        check("idle_vend_k5", 64'(b5.o_vend), 64'(1));
        tick();
        check("idle_vend_k3_end", 64'(b3.o_vend), 64'(0));
        check("idle_vend_k5_end", 64'(b5.o_vend), 64'(0));

        // Reset in the middle of a line; pending frame start is dropped too.
        vstr = 1'b1; tick(); vstr = 1'b0;
        sb_en = 1'b0;
        set_vals(50, 5, 5);
        for (int i = 0; i < 5; i++) begin
            data = 8'(vals[i]); href = 1'b1; hstr = (i == 0); pad_mode = 1'b1;
            tick();
        end
        href = 1'b0; hstr = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk_quiet("mid_reset");
        sb_en = 1'b1;
        vstr_m[0] = 1'b0; vstr_m[1] = 1'b0;
        set_vals(11, 1, 5);
        line(5, 1'b1, 0, 1'b0, 1'b0); repeat (5) tick();

        check("k3_sb_empty", 64'(sb[0].size()), 64'(0));
        check("k5_sb_empty", 64'(sb[1].size()), 64'(0));
        check("k3_err_count", 64'(errs[0]), 64'(exp_errs));
        check("k5_err_count", 64'(errs[1]), 64'(exp_errs));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
